yutorina_bus_arbiter: RTL and testbench

//  Shares one system bus between N bus masters (CPU i-port, CPU d-port, extra masters such as DMA).

---
 rtl/yutorina_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_yutorina_bus_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/yutorina_bus_arbiter.sv
// Round-robin arbiter that shares one system bus between MASTERS bus masters.
// It muxes the owner onto the slave side and aborts hung accesses with a watchdog.
module yutorina_bus_arbiter #(
    parameter int MASTERS = 4,
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MASTERS-1:0]          m_req_,
    output logic [MASTERS-1:0]          m_grnt_,
    input  logic [MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [MASTERS-1:0]          m_as_,
    input  logic [MASTERS-1:0]          m_rw,
    input  logic [MASTERS*DATA_W-1:0]   m_w_data,
    output logic [MASTERS-1:0]          m_rdy_,
    output logic [DATA_W-1:0]           m_r_data,
    output logic [ADDR_W-1:0]           s_addr,
    output logic                        s_as_,
    output logic                        s_rw,
    output logic [DATA_W-1:0]           s_w_data,
    input  logic [DATA_W-1:0]           s_r_data,
    input  logic                        s_rdy_,
    output logic [2:0]                  owner,
    output logic                        owned,
    output logic                        bus_err
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [2:0]         last;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         pick;
    logic               any_req;
    logic [MASTERS-1:0] grnt_next;
    int                 best_d;
    int                 d;

    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_w_data;
    logic               sel_as_;
    logic               sel_rw;
    logic               sel_req;
    logic               hold;
    logic               to_fire;

    // Distance from last+1 (mod MASTERS); the nearest requester wins.
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        best_d  = MASTERS;
        d       = 0;
        for (int i = 0; i < MASTERS; i++) begin
            d = i - int'(last) - 1;
            if (d < 0) d = d + MASTERS;
            if (!m_req_[i] && d < best_d) begin
                best_d  = d;
                pick    = 3'(i);
                any_req = 1'b1;
            end
        end
        grnt_next = '1;
        for (int i = 0; i < MASTERS; i++)
            if (pick == 3'(i)) grnt_next[i] = 1'b0;
    end

    always_comb begin
        sel_addr   = '0;
        sel_w_data = '0;
        sel_as_    = 1'b1;
        sel_rw     = 1'b1;
        sel_req    = 1'b1;
        for (int i = 0; i < MASTERS; i++) begin
            if (owner == 3'(i)) begin
                sel_addr   = m_addr[i*ADDR_W +: ADDR_W];
                sel_w_data = m_w_data[i*DATA_W +: DATA_W];
                sel_as_    = m_as_[i];
                sel_rw     = m_rw[i];
                sel_req    = m_req_[i];
            end
        end
    end

    assign hold = owned && !sel_req;
    // A real slave ready in the terminal count cycle takes precedence over the abort.
    assign to_fire = owned && (TIMEOUT != 0) && (cnt == CNT_MAX) && s_rdy_;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owned   <= 1'b0;
            owner   <= '0;
            last    <= 3'(MASTERS - 1);
            cnt     <= '0;
            m_grnt_ <= '1;
        end else begin
            if (!hold) begin
                if (any_req) begin
                    owned   <= 1'b1;
                    owner   <= pick;
                    last    <= pick;
                    m_grnt_ <= grnt_next;
                end else begin
                    owned   <= 1'b0;
                    m_grnt_ <= '1;
                end
            end
            if (hold && (TIMEOUT != 0) && !sel_as_ && s_rdy_ && !to_fire)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
        end
    end

    always_comb begin
        m_rdy_ = '1;
        for (int i = 0; i < MASTERS; i++)
            if (owned && owner == 3'(i)) m_rdy_[i] = to_fire ? 1'b0 : s_rdy_;
    end

    assign s_addr   = owned ? sel_addr : '0;
    assign s_as_    = owned ? (sel_as_ | to_fire) : 1'b1;
    assign s_rw     = owned ? sel_rw : 1'b1;
    assign s_w_data = owned ? sel_w_data : '0;
    assign m_r_data = (owned && !to_fire) ? s_r_data : '0;
    assign bus_err  = to_fire;

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// Directed bench for yutorina_bus_arbiter: arbitration order, muxing, watchdog, async reset.
module tb_yutorina_bus_arbiter;

    localparam int M  = 4;
    localparam int AW = 30;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [M-1:0]      m_req_;
    logic [M-1:0]      m_grnt_;
    logic [M*AW-1:0]   m_addr;
    logic [M-1:0]      m_as_;
    logic [M-1:0]      m_rw;
    logic [M*DW-1:0]   m_w_data;
    logic [M-1:0]      m_rdy_;
    logic [DW-1:0]     m_r_data;
    logic [AW-1:0]     s_addr;
    logic              s_as_;
    logic              s_rw;
    logic [DW-1:0]     s_w_data;
    logic [DW-1:0]     s_r_data;
    logic              s_rdy_;
    logic [2:0]        owner;
    logic              owned;
    logic              bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    yutorina_bus_arbiter #(.MASTERS(M), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .m_req_(m_req_), .m_grnt_(m_grnt_), .m_addr(m_addr),
        .m_as_(m_as_), .m_rw(m_rw), .m_w_data(m_w_data), .m_rdy_(m_rdy_),
        .m_r_data(m_r_data), .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw),
        .s_w_data(s_w_data), .s_r_data(s_r_data), .s_rdy_(s_rdy_), .owner(owner),
        .owned(owned), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_req_   = '1;
        m_as_    = '1;
        m_rw     = '1;
        m_addr   = '0;
        m_w_data = '0;
        s_rdy_   = 1'b1;
        s_r_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        do_reset();

        // reset state
        chk("rst_grnt", 64'(m_grnt_), 64'hF);
        chk("rst_rdy", 64'(m_rdy_), 64'hF);
        chk("rst_as", 64'(s_as_), 64'h1);
        chk("rst_rw", 64'(s_rw), 64'h1);
        chk("rst_addr", 64'(s_addr), 64'h0);
        chk("rst_wdata", 64'(s_w_data), 64'h0);
        chk("rst_owned", 64'(owned), 64'h0);
        chk("rst_err", 64'(bus_err), 64'h0);

        // 1: single request from master 0
        m_req_ = 4'b1110;
        chk("t1_pre_grnt", 64'(m_grnt_), 64'hF);
        step();
        chk("t1_grnt", 64'(m_grnt_), 64'hE);
        chk("t1_owner", 64'(owner), 64'h0);
        chk("t1_owned", 64'(owned), 64'h1);

        // 2: everyone requests, each owner releases for one cycle after two
        do_reset();
        m_req_ = 4'b0000;
        step();
        for (int k = 0; k < 5; k++) begin
            automatic int       x = k % M;
            automatic logic [3:0] g = 4'hF;
            g[x] = 1'b0;
            chk($sformatf("t2_owner%0d", k), 64'(owner), 64'(x));
            chk($sformatf("t2_grnt%0d", k), 64'(m_grnt_), 64'(g));
            chk($sformatf("t2_owned%0d", k), 64'(owned), 64'h1);
            step();
            chk($sformatf("t2_hold%0d", k), 64'(owner), 64'(x));
            m_req_[x] = 1'b1;
            step();
            m_req_[x] = 1'b0;
        end

        // 3: master 2 write, slave ready in third cycle
        do_reset();
        for (int i = 0; i < M; i++) begin
            m_addr[i*AW +: AW]   = 30'h3FFF_0000 | 30'(i);
            m_w_data[i*DW +: DW] = 32'h1111_1111 * i;
        end
        m_addr[2*AW +: AW]   = 30'h0000_1234;
        m_w_data[2*DW +: DW] = 32'hDEAD_BEEF;
        m_as_  = 4'b0000;
        m_rw   = 4'b1011;
        m_req_ = 4'b1011;
        step();
        chk("t3_owner", 64'(owner), 64'h2);
        chk("t3_rdy_c1", 64'(m_rdy_), 64'hF);
        step();
        chk("t3_rdy_c2", 64'(m_rdy_), 64'hF);
        s_rdy_ = 1'b0;
        #1;
        chk("t3_addr", 64'(s_addr), 64'h1234);
        chk("t3_wdata", 64'(s_w_data), 64'hDEAD_BEEF);
        chk("t3_rw", 64'(s_rw), 64'h0);
        chk("t3_as", 64'(s_as_), 64'h0);
        chk("t3_rdy_c3", 64'(m_rdy_), 64'hB);
        step();
        s_rdy_ = 1'b1;
        #1;
        chk("t3_rdy_c4", 64'(m_rdy_), 64'hF);

        // 4: master 1 read, slave never answers
        do_reset();
        m_req_   = 4'b1101;
        m_as_    = 4'b1101;
        s_r_data = 32'h5555_AAAA;
        step();
        chk("t4_owner", 64'(owner), 64'h1);
        for (int i = 0; i < 16; i++) begin
            if (bus_err !== 1'b0 || m_rdy_ !== 4'hF || m_r_data !== 32'h5555_AAAA)
                chk($sformatf("t4_wait%0d", i), {bus_err, m_rdy_, m_r_data}, {1'b0, 4'hF, 32'h5555_AAAA});
            step();
        end
        n_tests++;
        chk("t4_abort_rdy", 64'(m_rdy_), 64'hD);
        chk("t4_abort_data", 64'(m_r_data), 64'h0);
        chk("t4_abort_err", 64'(bus_err), 64'h1);
        chk("t4_abort_as", 64'(s_as_), 64'h1);
        step();
        chk("t4_after_err", 64'(bus_err), 64'h0);
        chk("t4_after_rdy", 64'(m_rdy_), 64'hF);
        chk("t4_after_as", 64'(s_as_), 64'h0);

        // 5: release and re-request without and with contention
        do_reset();
        m_req_ = 4'b1110;
        step();
        chk("t5_owner0", 64'(owner), 64'h0);
        m_req_ = 4'b1111;
        step();
        chk("t5_released", 64'(owned), 64'h0);
        m_req_ = 4'b1110;
        step();
        chk("t5_regrant", 64'(owner), 64'h0);
        chk("t5_regrant_grnt", 64'(m_grnt_), 64'hE);
        m_req_ = 4'b0110;
        step();
        chk("t5_keep0", 64'(owner), 64'h0);
        m_req_ = 4'b0111;
        step();
        chk("t5_move3", 64'(owner), 64'h3);
        chk("t5_move3_grnt", 64'(m_grnt_), 64'h7);
        chk("t5_move3_owned", 64'(owned), 64'h1);

        // 6: async reset mid-access
        do_reset();
        m_req_ = 4'b1101;
        m_as_  = 4'b1101;
        step();
        chk("t6_owner1", 64'(owner), 64'h1);
        chk("t6_as_pre", 64'(s_as_), 64'h0);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_grnt", 64'(m_grnt_), 64'hF);
        chk("t6_rst_as", 64'(s_as_), 64'h1);
        chk("t6_rst_owned", 64'(owned), 64'h0);
        rst = 1'b0;
        m_as_  = 4'b1111;
        m_req_ = 4'b0000;
        step();
        chk("t6_after_owner", 64'(owner), 64'h0);
        chk("t6_after_grnt", 64'(m_grnt_), 64'hE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
